// File: rtl/sr_cmd_debouncer_pkg.sv
// sr_ctrl_pkg: shared definitions for driving the SR flip-flop.
//
// {s,r} encoding used by the command front end and by the flip-flop bench:
//   SR_HOLD    2'b00  flip-flop keeps its state
//   SR_RESET   2'b01  clear
//   SR_SET     2'b10  set
//   SR_INVALID 2'b11  forbidden; must never reach the flip-flop
//
// Also provides the arbitration helper that turns the two per-channel rising
// edges into one registered output word.
package sr_ctrl_pkg;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_INVALID = 2'b11;

    // Next values of the three output registers.
    typedef struct packed {
        logic s;
        logic r;
        logic conflict;
    } sr_out_t;

    // One edge alone becomes a command; coincident edges become a conflict
    // pulse and the flip-flop is told to hold.
    function automatic sr_out_t arbitrate(input logic set_rise, input logic reset_rise);
        sr_out_t    o;
        logic [1:0] cmd;
        o   = '0;
        cmd = SR_HOLD;
        case ({set_rise, reset_rise})
            2'b10:   cmd = SR_SET;
            2'b01:   cmd = SR_RESET;
            2'b11:   o.conflict = 1'b1;
            default: cmd = SR_HOLD;
        endcase
        // Belt and braces: the forbidden code is squashed even if the table
        // above is ever edited carelessly.
        if (cmd == SR_INVALID) begin
            cmd = SR_HOLD;
        end
        o.s = cmd[1];
        o.r = cmd[0];
        return o;
    endfunction

endpackage

// File: rtl/sr_cmd_debouncer_if.sv
// sr_cmd_debouncer_if: button inputs and flip-flop command outputs of the
// command debouncer.
//
// Signals:
//   set_btn    raw set request (asynchronous, may bounce)
//   reset_btn  raw reset request (asynchronous, may bounce)
//   s          one-cycle set pulse to the flip-flop
//   r          one-cycle reset pulse to the flip-flop
//   conflict   one-cycle pulse when set and reset edges coincide
//
// Modports:
//   master  drives the buttons, observes the commands (bench / button side)
//   slave   the debouncer itself
interface sr_cmd_debouncer_if;

    logic set_btn;
    logic reset_btn;
    logic s;
    logic r;
    logic conflict;

    modport master (
        output set_btn,
        output reset_btn,
        input  s,
        input  r,
        input  conflict
    );

    modport slave (
        input  set_btn,
        input  reset_btn,
        output s,
        output r,
        output conflict
    );

endinterface

// File: rtl/sr_cmd_debouncer_debounce_channel.sv
// debounce_channel: one button line -> synchronised, debounced, rising-edge
// strobe.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   btn    raw asynchronous button level
//   rise   high for one cycle after the debounced level goes 0 -> 1
//
// The debounced level flips only after the synchronised input has disagreed
// with it on DEBOUNCE_CYCLES consecutive clock edges; any agreement in between
// clears the count, so short glitches leave no trace.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Counter stops at CNT_MAX: reaching it either flips the level (and
    // clears) or the input agrees again (and clears), so it cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
        end
    end

    // Only presses matter; releases are debounced but produce no strobe.
    assign rise = db_q & ~db_dly_q;

endmodule

// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: drives the SR flip-flop's s/r inputs from two bouncy
// buttons.
//
// Ports:
//   clk    clock; all state updates on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    sr_cmd_debouncer_if.slave
//            set_btn, reset_btn  raw button inputs
//            s, r                registered one-cycle commands
//            conflict            registered one-cycle pulse on coincident edges
//
// Each button goes through its own debounce_channel. The top only arbitrates
// the two rising-edge strobes and registers the result, so {s,r} is never
// 2'b11 and each accepted press yields exactly one output pulse.
module sr_cmd_debouncer
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input logic               clk,
    input logic               rst_n,
    sr_cmd_debouncer_if.slave bus
);

    logic    set_rise;
    logic    reset_rise;
    sr_out_t out_d;
    sr_out_t out_q;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set_channel (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.set_btn),
        .rise  (set_rise)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset_channel (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.reset_btn),
        .rise  (reset_rise)
    );

    always_comb begin
        out_d = arbitrate(set_rise, reset_rise);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.s        = out_q.s;
    assign bus.r        = out_q.r;
    assign bus.conflict = out_q.conflict;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Bench for sr_cmd_debouncer: directed scenarios plus random button activity.
// The stimulus process feeds a window-based reference model that pushes the
// expected output pulses (cycle and kind) into a queue; a negedge monitor pops
// and compares against what the DUT presents.
module tb_sr_cmd_debouncer;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n;

    sr_cmd_debouncer_if bus ();

    sr_cmd_debouncer #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edges seen so far; after edge t the monitor sees cyc == t+1.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned when;
        logic [2:0]  kind;  // {s, r, conflict}
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned s_cnt = 0, r_cnt = 0, c_cnt = 0;
    int unsigned last_s_cyc = 0, last_r_cyc = 0;

    // ---------------- reference model ----------------
    // hist[c][i]: raw level sampled i edges ago (i = 0 is the current edge).
    // The level a channel acts on at edge t is the raw sample from edge t-2;
    // the debounced level flips when the last N such samples all disagree
    // with it.
    logic hist [2][N+2];
    logic mdb  [2];

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < int'(N) + 2; i++) hist[c][i] = 1'b0;
            mdb[c] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic sb, input logic rb, input int unsigned t);
        logic in_v [2];
        logic rise [2];
        logic all_diff;
        exp_t e;
        in_v[0] = sb;
        in_v[1] = rb;
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            for (int i = int'(N) + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = in_v[c];
            all_diff = 1'b1;
            for (int j = 0; j < int'(N); j++) begin
                if (hist[c][2+j] == mdb[c]) all_diff = 1'b0;
            end
            rise[c] = all_diff && !mdb[c];
            if (all_diff) mdb[c] = ~mdb[c];
        end
        e.when = t + 2;
        e.kind = 3'b000;
        if (rise[0] && rise[1]) e.kind = 3'b001;
        else if (rise[0])       e.kind = 3'b100;
        else if (rise[1])       e.kind = 3'b010;
        if (e.kind != 3'b000) exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [2:0] obs;
        logic [2:0] expv;
        obs  = {bus.s, bus.r, bus.conflict};
        expv = 3'b000;
        while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
            checks++;
            failures++;
            $display("FAIL stale_expect cyc=%0d expected kind=%b due at cyc %0d never matched",
                     cyc, exp_q[0].kind, exp_q[0].when);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
            expv = exp_q[0].kind;
            void'(exp_q.pop_front());
        end
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL pulse cyc=%0d got {s,r,conflict}=%b want %b", cyc, obs, expv);
        end
        checks++;
        if ((bus.s & bus.r) !== 1'b0) begin
            failures++;
            $display("FAIL s_and_r cyc=%0d got s=%b r=%b want not both 1", cyc, bus.s, bus.r);
        end
        if (bus.s === 1'b1) begin s_cnt++; last_s_cyc = cyc; end
        if (bus.r === 1'b1) begin r_cnt++; last_r_cyc = cyc; end
        if (bus.conflict === 1'b1) c_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int unsigned act, input int unsigned want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    // One clock edge with the given button levels and reset level.
    task automatic step(input logic sb, input logic rb, input logic rn, output int unsigned t);
        @(negedge clk);
        #1;
        // Async reset kills any pulse still in flight.
        if (!rn && rst_n) exp_q.delete();
        rst_n         = rn;
        bus.set_btn   = sb;
        bus.reset_btn = rb;
        @(posedge clk);
        t = cyc;
        model_edge(sb, rb, t);
    endtask

    task automatic idle(input int unsigned n);
        int unsigned t;
        repeat (n) step(1'b0, 1'b0, 1'b1, t);
    endtask

    task automatic hold(input logic sb, input logic rb, input int unsigned n);
        int unsigned t;
        repeat (n) step(sb, rb, 1'b1, t);
    endtask

    initial begin
        int unsigned k, k2, t, s0, r0, c0;
        logic        sb, rb, rn;
        int unsigned len;

        rst_n         = 1'b0;
        bus.set_btn   = 1'b1;
        bus.reset_btn = 1'b1;
        model_clear();

        // Reset with both buttons high: outputs stay low.
        repeat (3) step(1'b1, 1'b1, 1'b0, t);
        #2;
        check("reset_outputs", {29'd0, bus.s, bus.r, bus.conflict}, 0);

        // Release with set held: one s pulse, full latency from release.
        s0 = s_cnt; r0 = r_cnt;
        step(1'b1, 1'b0, 1'b1, k);
        hold(1'b1, 1'b0, 15);
        check("release_held_s_count", s_cnt - s0, 1);
        check("release_held_s_cycle", last_s_cyc, k + 7);
        check("release_held_r_count", r_cnt - r0, 0);
        idle(10);

        // Clean set press, then clean reset press.
        s0 = s_cnt; r0 = r_cnt;
        step(1'b1, 1'b0, 1'b1, k);
        hold(1'b1, 1'b0, 19);
        check("clean_s_count", s_cnt - s0, 1);
        check("clean_s_cycle", last_s_cyc, k + 7);
        check("clean_r_quiet", r_cnt - r0, 0);
        idle(10);
        s0 = s_cnt;
        step(1'b0, 1'b1, 1'b1, k);
        hold(1'b0, 1'b1, 19);
        check("clean_r_count", r_cnt - r0, 1);
        check("clean_r_cycle", last_r_cyc, k + 7);
        check("clean_s_quiet", s_cnt - s0, 0);
        idle(10);

        // Bounce 1,0,1,1,0,1 then steady 1.
        s0 = s_cnt;
        step(1'b1, 1'b0, 1'b1, t);
        step(1'b0, 1'b0, 1'b1, t);
        step(1'b1, 1'b0, 1'b1, t);
        step(1'b1, 1'b0, 1'b1, t);
        step(1'b0, 1'b0, 1'b1, t);
        step(1'b1, 1'b0, 1'b1, k);
        hold(1'b1, 1'b0, 14);
        check("bounce_s_count", s_cnt - s0, 1);
        check("bounce_s_cycle", last_s_cyc, k + 7);
        idle(10);

        // Simultaneous presses.
        s0 = s_cnt; r0 = r_cnt; c0 = c_cnt;
        step(1'b1, 1'b1, 1'b1, k);
        hold(1'b1, 1'b1, 14);
        check("simul_conflict_count", c_cnt - c0, 1);
        check("simul_s_count", s_cnt - s0, 0);
        check("simul_r_count", r_cnt - r0, 0);
        idle(10);

        // Presses one edge apart.
        s0 = s_cnt; r0 = r_cnt; c0 = c_cnt;
        step(1'b1, 1'b0, 1'b1, k);
        hold(1'b1, 1'b1, 14);
        check("offset_s_cycle", last_s_cyc, k + 7);
        check("offset_r_cycle", last_r_cyc, k + 8);
        check("offset_conflict", c_cnt - c0, 0);
        check("offset_counts", (s_cnt - s0) + (r_cnt - r0), 2);
        idle(10);

        // Reset mid-count, button still held through and after reset.
        s0 = s_cnt;
        step(1'b1, 1'b0, 1'b1, k);
        hold(1'b1, 1'b0, 3);
        repeat (3) step(1'b1, 1'b0, 1'b0, t);
        step(1'b1, 1'b0, 1'b1, k2);
        hold(1'b1, 1'b0, 14);
        check("midreset_s_count", s_cnt - s0, 1);
        check("midreset_s_cycle", last_s_cyc, k2 + 7);
        idle(10);

        // Random activity, occasional resets.
        for (int seg = 0; seg < 200; seg++) begin
            sb  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            rn  = ($urandom_range(0, 19) != 0);
            len = rn ? $urandom_range(1, 8) : $urandom_range(1, 3);
            repeat (len) step(sb, rb, rn, t);
        end

        idle(15);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_cmd_debouncer.md
# sr_cmd_debouncer

Front-end stage that drives the SR flip-flop's `s`/`r` inputs from two raw, bouncy, asynchronous request lines (set button, reset button). Each line is synchronised, debounced and edge-detected. The block emits single-cycle `s` or `r` pulses and guarantees the invalid `{s,r}=2'b11` combination never reaches the flip-flop. Its outputs connect directly to the flip-flop's `s` and `r` ports in the same clock domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronised input must differ from its debounced level before the level flips. Legal range 2..65535.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `set_btn`  in  1  raw set request; asynchronous, may bounce.
- `reset_btn`  in  1  raw reset request; asynchronous, may bounce.
- `s`  out  1  registered one-cycle set pulse to the flip-flop.
- `r`  out  1  registered one-cycle reset pulse to the flip-flop.
- `conflict`  out  1  registered one-cycle pulse when set and reset edges coincide.

## Operation
- **Per channel, synchroniser:** 2-flop synchroniser; `sync2` is the second stage.
- **Per channel, counter:** `cnt` (CNT_W bits) and debounced level `db`.
  - If `sync2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= ~db`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - The counter never wraps; it saturates by construction at DEBOUNCE_CYCLES-1.
- **Per channel, edge detect:** `db_d` holds `db` delayed one cycle; `rise = db & ~db_d`. Falling edges produce no command.
- **Arbitration (registered outputs):**
  - `set_rise` only: `s <= 1`.
  - `reset_rise` only: `r <= 1`.
  - Both in the same cycle: `s <= 0`, `r <= 0`, `conflict <= 1`. The flip-flop holds its state.
  - Neither: all three outputs 0.
- **Invariants:**
  - `s & r` is 0 in every cycle.
  - Each output is high for exactly one cycle per accepted edge.
  - Holding a button high produces exactly one pulse.
- **Glitches:** a pulse on `sync2` shorter than DEBOUNCE_CYCLES cycles clears `cnt` and causes no `db` change and no output.
- **Separate edges:** edges on the two channels in different cycles, even one cycle apart, each produce their own pulse, in order.

## Timing
- **Reset values:** while `rst_n=0`, all synchroniser flops, `cnt`, `db`, `db_d`, `s`, `r` and `conflict` are 0, asynchronously. If reset asserts mid-count, the partial count is discarded.
- **Reset release with input held high:** if a button is already high when `rst_n` deasserts, it is debounced and produces one pulse, the same as a fresh press.
- **Latency:** the raw input is first sampled high at edge k and stays stable.
  - `sync2`=1 after edge k+1.
  - `db` flips at edge k+1+N (N = DEBOUNCE_CYCLES).
  - `s` (or `r`) is high for the cycle following edge k+2+N.
  - With N=4, the pulse follows edge k+6.
- **Release:** debounced the same way, with no output. The next press requires `db` to have returned to 0 first.
- **No backpressure:** there is no handshake; the flip-flop consumes a pulse on the same edge it is presented.

## Structure
- **Shared package `sr_ctrl_pkg`:**
  - Localparams `SR_HOLD=2'b00`, `SR_RESET=2'b01`, `SR_SET=2'b10`, `SR_INVALID=2'b11`.
  - The `{s,r}` encoding used here and by the flip-flop bench.
- **Sub-module `debounce_channel`:**
  - Contains the synchroniser, counter, `db`, `db_d` and the `rise` output.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated twice.
- **Top level:** arbitration and output registers only.

## Test plan
- **Reset:** assert `rst_n=0` with both buttons high → `s=r=conflict=0`. Release reset with `set_btn` still high → one `s` pulse 6 edges later (N=4), then no further pulses.
- **Clean press:** raise `set_btn` at edge 10 and hold it for 20 cycles → `s`=1 only in the cycle after edge 16; `r=0` throughout. Release, then press `reset_btn` → one `r` pulse with the same latency.
- **Bounce:** `set_btn` sequence 1,0,1,1,0,1 (one cycle each), then steady 1 → no pulse during the bounce. Exactly one `s` pulse N+2 edges after the start of the steady level.
- **Simultaneous:** raise `set_btn` and `reset_btn` on the same edge → `conflict` pulses once; `s=r=0` in every cycle.
- **Offset by one:** raise `set_btn` at edge 20 and `reset_btn` at edge 21 → `s` pulse after edge 26, `r` pulse after edge 27, `conflict=0`.
- **Reset mid-count:** raise `set_btn`, assert `rst_n=0` at count 2, release after 3 cycles with `set_btn` still high → `cnt` restarts from 0; a single `s` pulse follows the full latency measured from reset release.
